// File: rtl/stbus_rx_deframer.sv
// -----------------------------------------------------------------------------
// stbus_rx_deframer
//
// Receives a serial ST-bus style TDM stream (bit clock c4, active-low frame
// pulse f0, MSB-first data) and assembles each complete frame into a
// FRAME_BITS-wide image. A completed frame is copied into a shadow buffer that
// the CPU reads byte by byte, and a level interrupt is raised once per frame.
// Everything runs on clk50; c4, f0 and data_from_dt are asynchronous and are
// oversampled through synchronizer chains.
//
// Ports:
//   clk50        in   system clock (c4 is at most clk50/4)
//   reset_in_rg  in   asynchronous active-low reset
//   c4           in   TDM bit clock, asynchronous
//   f0           in   frame pulse, active low, asynchronous
//   data_from_dt in   serial TDM data, MSB first per channel
//   rd_addr      in   shadow byte index 0..CH-1
//   rd_data      out  registered shadow byte at rd_addr (0x00 if out of range)
//   int_ack      in   single-cycle pulse clearing cpu_int
//   cpu_int      out  frame-ready interrupt (level)
//   frame_err    out  sticky: early or missing frame pulse seen
//   overrun      out  sticky: frame completed while cpu_int still pending
//   locked       out  high while the receiver is in RECV
//   frame_cnt    out  completed-frame counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module stbus_rx_deframer #(
    parameter int FRAME_BITS  = 384,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk50,
    input  logic       reset_in_rg,
    input  logic       c4,
    input  logic       f0,
    input  logic       data_from_dt,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       int_ack,
    output logic       cpu_int,
    output logic       frame_err,
    output logic       overrun,
    output logic       locked,
    output logic [7:0] frame_cnt
);

    localparam int              CH       = FRAME_BITS / 8;
    localparam int              BCW      = $clog2(FRAME_BITS);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(FRAME_BITS - 1);
    localparam logic [6:0]      CH_LIM   = 7'(CH);

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    // Byte idx of an image; byte 0 is the top (first received) byte.
    function automatic logic [7:0] get_byte(input logic [FRAME_BITS-1:0] img,
                                            input logic [5:0]            idx);
        logic [FRAME_BITS-1:0] sh;
        sh = img << {idx, 3'b000};
        return sh[FRAME_BITS-1 -: 8];
    endfunction

    // Synchronizers and edge detector
    logic [SYNC_STAGES-1:0] c4_sync_r;
    logic [SYNC_STAGES-1:0] f0_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   c4_prev_r;
    logic                   c4_rise_s;
    logic                   f0_s;
    logic                   data_s;

    // Receiver state
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [BCW-1:0]         bitcnt_r;
    logic [BCW-1:0]         bitcnt_nxt_s;
    logic [BCW-1:0]         pos_s;
    logic [FRAME_BITS-1:0]  asm_r;
    logic [FRAME_BITS-1:0]  asm_nxt_s;
    logic                   done_r;
    logic                   done_nxt_s;
    logic                   err_s;

    // CPU side
    logic [FRAME_BITS-1:0]  shadow_r;
    logic [FRAME_BITS-1:0]  rd_src_s;
    logic [7:0]             rd_data_r;
    logic                   cpu_int_r;
    logic                   frame_err_r;
    logic                   overrun_r;
    logic                   locked_r;
    logic [7:0]             frame_cnt_r;

    // Synchronizer chains; f0 idles high so a reset release never looks like a frame pulse.
    always_ff @(posedge clk50 or negedge reset_in_rg) begin
        if (!reset_in_rg) begin
            c4_sync_r   <= {SYNC_STAGES{1'b0}};
            f0_sync_r   <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b0}};
            c4_prev_r   <= 1'b0;
        end else begin
            c4_sync_r   <= {c4_sync_r[SYNC_STAGES-2:0], c4};
            f0_sync_r   <= {f0_sync_r[SYNC_STAGES-2:0], f0};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], data_from_dt};
            c4_prev_r   <= c4_sync_r[SYNC_STAGES-1];
        end
    end

    // All three chains have equal depth, so f0/data line up with the c4 edge.
    assign c4_rise_s = c4_sync_r[SYNC_STAGES-1] & ~c4_prev_r;
    assign f0_s      = f0_sync_r[SYNC_STAGES-1];
    assign data_s    = data_sync_r[SYNC_STAGES-1];
    assign pos_s     = LAST_BIT - bitcnt_r;

    // Next-state, bit counter and assembly logic
    always_comb begin
        state_nxt_s  = state_r;
        bitcnt_nxt_s = bitcnt_r;
        asm_nxt_s    = asm_r;
        done_nxt_s   = 1'b0;
        err_s        = 1'b0;
        if (c4_rise_s) begin
            case (state_r)
                HUNT: begin
                    if (!f0_s) begin
                        asm_nxt_s                 = {FRAME_BITS{1'b0}};
                        asm_nxt_s[FRAME_BITS-1]   = data_s;
                        bitcnt_nxt_s              = BCW'(1);
                        state_nxt_s               = RECV;
                    end else begin
                        state_nxt_s = HUNT;
                    end
                end
                RECV: begin
                    if (!f0_s) begin
                        // Frame start; a nonzero count means the pulse came early.
                        err_s                     = (bitcnt_r != {BCW{1'b0}});
                        asm_nxt_s                 = {FRAME_BITS{1'b0}};
                        asm_nxt_s[FRAME_BITS-1]   = data_s;
                        bitcnt_nxt_s              = BCW'(1);
                    end else if (bitcnt_r == {BCW{1'b0}}) begin
                        // Expected frame pulse did not arrive: drop lock.
                        err_s       = 1'b1;
                        state_nxt_s = HUNT;
                    end else begin
                        asm_nxt_s[pos_s] = data_s;
                        if (bitcnt_r == LAST_BIT) begin
                            done_nxt_s   = 1'b1;
                            bitcnt_nxt_s = {BCW{1'b0}};
                        end else begin
                            bitcnt_nxt_s = bitcnt_r + BCW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt_s  = HUNT;
                    bitcnt_nxt_s = {BCW{1'b0}};
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk50 or negedge reset_in_rg) begin
        if (!reset_in_rg) begin
            state_r  <= HUNT;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            locked_r <= (state_nxt_s == RECV);
        end
    end

    // Bit counter, assembly register and completion strobe
    always_ff @(posedge clk50 or negedge reset_in_rg) begin
        if (!reset_in_rg) begin
            bitcnt_r <= {BCW{1'b0}};
            asm_r    <= {FRAME_BITS{1'b0}};
            done_r   <= 1'b0;
        end else begin
            bitcnt_r <= bitcnt_nxt_s;
            asm_r    <= asm_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    // Shadow copy, interrupt, sticky flags and frame counter.
    // c4 edges are at least 4 clk50 apart, so asm_r is stable while done_r is high.
    always_ff @(posedge clk50 or negedge reset_in_rg) begin
        if (!reset_in_rg) begin
            shadow_r    <= {FRAME_BITS{1'b0}};
            cpu_int_r   <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            frame_err_r <= frame_err_r | err_s;
            if (done_r) begin
                shadow_r    <= asm_r;
                frame_cnt_r <= frame_cnt_r + 8'd1;
                cpu_int_r   <= 1'b1;
                // An ack landing with the completion counts as servicing the old frame.
                overrun_r   <= overrun_r | (cpu_int_r & ~int_ack);
            end else if (int_ack) begin
                cpu_int_r   <= 1'b0;
            end else begin
                cpu_int_r   <= cpu_int_r;
            end
        end
    end

    // A read during the shadow copy sees the frame being copied in.
    assign rd_src_s = done_r ? asm_r : shadow_r;

    // Registered byte read port
    always_ff @(posedge clk50 or negedge reset_in_rg) begin
        if (!reset_in_rg) begin
            rd_data_r <= 8'h00;
        end else if ({1'b0, rd_addr} < CH_LIM) begin
            rd_data_r <= get_byte(rd_src_s, rd_addr);
        end else begin
            rd_data_r <= 8'h00;
        end
    end

    assign rd_data   = rd_data_r;
    assign cpu_int   = cpu_int_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;
    assign locked    = locked_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: doc/stbus_rx_deframer.md
Name: stbus_rx_deframer

Overview:
- Receives the serial ST-bus-style TDM stream on data_from_dt, timed by c4 and framed by f0.
- Assembles each complete frame into a 384-bit image, copies it into a shadow buffer that the CPU reads as bytes, and raises cpu_int once per frame.
- Sits upstream of the STM-side shift path. The frame width matches that path so a whole frame can be handed over unchanged.
- Runs entirely on clk50. c4, f0 and data_from_dt are treated as asynchronous inputs and are oversampled.

Parameters:
- FRAME_BITS, 384, bits per frame; must be a multiple of 8. Channel count CH = FRAME_BITS/8 = 48.
- SYNC_STAGES, 2, flip-flop synchronizer depth on c4, f0 and data_from_dt.

Ports:
- clk50 in 1: system clock. c4 is guaranteed to be no faster than clk50/4.
- reset_in_rg in 1: asynchronous, active-low reset.
- c4 in 1: TDM bit clock. Asynchronous to clk50.
- f0 in 1: frame pulse, active low. Asynchronous.
- data_from_dt in 1: serial TDM data, MSB-first per channel.
- rd_addr in 6: byte index into the shadow buffer, 0..CH-1.
- rd_data out 8: shadow byte at rd_addr, registered.
- int_ack in 1: single-cycle pulse that clears cpu_int.
- cpu_int out 1: frame-ready interrupt, level.
- frame_err out 1: sticky error. Set on an early f0 or a missing f0.
- overrun out 1: sticky. Set when a frame completes while cpu_int is still pending.
- locked out 1: high while the FSM is in RECV.
- frame_cnt out 8: number of completed frames, wraps at 255 to 0.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0. FSM is in HUNT. Bit counter is 0. Shadow buffer and assembly register are 0.
  - frame_err and overrun clear only on reset.
- Synchronization and edge detection:
  - c4, f0 and data_from_dt each pass through SYNC_STAGES flops.
  - c4_rise is a one-clk50 pulse when the synchronized c4 goes 0 to 1.
  - All TDM sampling happens only on clk50 cycles where c4_rise=1. The synchronized f0 and data are sampled in that same cycle.
- Bit counter bitcnt:
  - Counts 0..FRAME_BITS-1.
  - Bit bitcnt is written to assembly position FRAME_BITS-1-bitcnt, so channel 0 MSB is received first and lands in the top bits.
- FSM states:
  - HUNT:
    - On c4_rise with f0=0: capture data as bit 0, set bitcnt=1, go to RECV.
    - Otherwise stay in HUNT.
  - RECV (locked=1), on each c4_rise:
    - f0=0 with bitcnt != 0: early frame. Set frame_err. Discard the partial frame. Treat this bit as bit 0 of a new frame (bitcnt=1). Stay in RECV.
    - f0=0 with bitcnt == 0: normal frame start. Capture the bit and set bitcnt=1.
    - f0=1 with bitcnt == 0: missing frame pulse. Set frame_err. Go to HUNT; this bit is not captured.
    - Otherwise: capture the bit and increment bitcnt.
    - When the bit just captured is bit FRAME_BITS-1: raise the completion strobe and set bitcnt=0.
- Completion strobe (one clk50 cycle after the last bit is captured):
  - The full assembly register, including the last bit, is copied into the shadow buffer.
  - frame_cnt increments.
  - cpu_int is set to 1.
  - If cpu_int was already 1 and int_ack is not asserted in this cycle, overrun is set. The shadow buffer is overwritten regardless.
- Interrupt handshake:
  - int_ack=1 clears cpu_int on the next edge.
  - If int_ack and the completion strobe occur in the same cycle, completion wins: cpu_int stays 1 and overrun is not set.
- Read port:
  - rd_data is updated one clk50 after rd_addr is presented.
  - Byte k corresponds to channel k, MSB is the first bit received.
  - rd_addr >= CH returns 0x00.
  - If a read coincides with the shadow copy, it returns the new frame's byte.
- Reset mid-frame: the partial frame is discarded, the FSM returns to HUNT, and cpu_int drops immediately.

Test Plan:
- Frame start, channel 0 = 0xA5, channel 47 = 0x3C, rest zero, f0 low only on bit 0 → after the last bit: cpu_int=1, frame_cnt=1, rd_addr=0 gives 0xA5 after 1 clk, rd_addr=47 gives 0x3C, frame_err=0, locked=1.
- Three consecutive frames with ch5 = 0x01, 0x02, 0x03, each acknowledged with int_ack before the next completes → frame_cnt=3, rd_addr=5 gives 0x03, overrun=0.
- Two frames completed without int_ack → overrun=1, cpu_int stays 1, shadow holds the second frame's data.
- f0 low at bit 200 → frame_err=1, no cpu_int for the truncated frame. The next full frame counted from bit 200 completes normally and cpu_int=1.
- f0 held high at an expected frame boundary → frame_err=1, locked=0 (HUNT). The next f0 low relocks and the following frame completes.
- reset_in_rg pulsed low at bit 100 → all outputs 0 within the same cycle, no interrupt, relock on the next f0. Also: int_ack coinciding with the completion strobe → cpu_int=1, overrun=0. Also: rd_addr=50 → rd_data=0x00.
